// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state type and default sizes shared by the adder and its initiators.
package serial_adder_pkg;
    localparam int ADDER_WIDTH = 9;
    localparam int ADDER_DIGIT = 3;
    typedef enum logic [1:0] {
        Adder_Idle,
        Adder_Compute,
        Adder_Ack,
        Adder_Gap
    } AdderState;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/response bundle between an initiator and serial_adder.
interface serial_adder_if #(parameter int WIDTH = serial_adder_pkg::ADDER_WIDTH);
    logic [WIDTH-1:0] Adder_datain1;
    logic [WIDTH-1:0] Adder_datain2;
    logic             Adder_valid;
    logic [WIDTH-1:0] Adder_dataout;
    logic             Adder_carryout;
    logic             Adder_ack;
    modport master (
        output Adder_datain1, Adder_datain2, Adder_valid,
        input  Adder_dataout, Adder_carryout, Adder_ack
    );
    modport slave (
        input  Adder_datain1, Adder_datain2, Adder_valid,
        output Adder_dataout, Adder_carryout, Adder_ack
    );
endinterface

// File: rtl/serial_adder_digit_add.sv
// digit_add: combinational DIGIT-bit adder slice with carry in and carry out.
module digit_add #(parameter int DIGIT = serial_adder_pkg::ADDER_DIGIT) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_ci,
    output logic [DIGIT-1:0] o_s,
    output logic             o_co
);
    logic [DIGIT:0] w_r;
    assign w_r = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_ci};
    assign {o_co, o_s} = w_r;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit operands DIGIT bits per cycle and acknowledges with a
// one-cycle pulse, followed by a mandatory gap cycle before the next request is accepted.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int DIGIT = ADDER_DIGIT
) (
    input  logic          CLK,
    input  logic          RSTK,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);
    AdderState r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_dout, w_sum;
    logic [WIDTH-DIGIT-1:0] r_sum;
    logic [CW-1:0] r_cnt;
    logic [DIGIT-1:0] w_s;
    logic r_carry, r_cout, r_ack, w_co, w_last;
    digit_add #(.DIGIT(DIGIT)) u_digit (
        .i_a (r_a[DIGIT-1:0]),
        .i_b (r_b[DIGIT-1:0]),
        .i_ci(r_carry),
        .o_s (w_s),
        .o_co(w_co)
    );
    // Completed slices enter at the top so the LSB slice ends up at bit 0 after N shifts.
    assign w_sum  = {w_s, r_sum};
    assign w_last = r_cnt == CW'(N - 1);
    always_comb begin
        w_next = r_state == Adder_Idle    ? (bus.Adder_valid ? Adder_Compute : Adder_Idle) :
                 r_state == Adder_Compute ? (w_last ? Adder_Ack : Adder_Compute) :
                 r_state == Adder_Ack     ? Adder_Gap : Adder_Idle;
    end
    always_ff @(posedge CLK) begin
        if (!RSTK) r_state <= Adder_Idle;
        else       r_state <= w_next;
    end
    always_ff @(posedge CLK) begin
        if (!RSTK) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_dout  <= '0;
            r_cout  <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= w_next == Adder_Ack;
            if (r_state == Adder_Idle && bus.Adder_valid) begin
                r_a     <= bus.Adder_datain1;
                r_b     <= bus.Adder_datain2;
                r_carry <= 1'b0;
                r_cnt   <= '0;
            end else if (r_state == Adder_Compute) begin
                r_a     <= r_a >> DIGIT;
                r_b     <= r_b >> DIGIT;
                r_carry <= w_co;
                r_cnt   <= r_cnt + 1'b1;
                r_sum   <= w_sum[WIDTH-1:DIGIT];
                if (w_last) begin
                    r_dout <= w_sum;
                    r_cout <= w_co;
                end
            end
        end
    end
    assign bus.Adder_dataout  = r_dout;
    assign bus.Adder_carryout = r_cout;
    assign bus.Adder_ack      = r_ack;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random requests checked against an arithmetic model of a+b.
module tb_serial_adder;
    localparam int W = 9;
    logic CLK = 1'b0;
    logic RSTK = 1'b0;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder #(.WIDTH(W), .DIGIT(3)) dut (.CLK(CLK), .RSTK(RSTK), .bus(bus));
    always #5 CLK = ~CLK;

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Drives a request in the current cycle and waits (bounded) for the ack; lat = cycles to ack.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                         output logic [W-1:0] d, output logic c);
        bus.Adder_datain1 = a;
        bus.Adder_datain2 = b;
        bus.Adder_valid = 1'b1;
        lat = -1;
        d = '0;
        c = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (bus.Adder_ack) begin
                lat = n;
                d = bus.Adder_dataout;
                c = bus.Adder_carryout;
                break;
            end
        end
        bus.Adder_valid = 1'b0;
    endtask

    task automatic test_reset();
        RSTK = 1'b0;
        bus.Adder_valid = 1'b1;
        bus.Adder_datain1 = 9'h1AA;
        bus.Adder_datain2 = 9'h055;
        repeat (3) begin
            tick();
            total++;
            if ({bus.Adder_ack, bus.Adder_carryout, bus.Adder_dataout} !== 11'h0) begin
                bad++;
                $display("FAIL reset_outputs got=%h exp=0", {bus.Adder_ack, bus.Adder_carryout, bus.Adder_dataout});
            end
        end
    endtask

    task automatic test_add();
        int lat;
        logic [W-1:0] d;
        logic c;
        RSTK = 1'b1;
        do_op(9'h005, 9'h003, lat, d, c);
        total++;
        if (lat !== 4) begin bad++; $display("FAIL add_latency got=%0d exp=4", lat); end
        total++;
        if (d !== 9'h008) begin bad++; $display("FAIL add_dataout got=%h exp=008", d); end
        total++;
        if (c !== 1'b0) begin bad++; $display("FAIL add_carry got=%b exp=0", c); end
        tick();
        total++;
        if (bus.Adder_ack !== 1'b0) begin bad++; $display("FAIL add_ack_width got=%b exp=0", bus.Adder_ack); end
        tick();
    endtask

    task automatic test_wrap();
        int lat;
        logic [W-1:0] d;
        logic c;
        do_op(9'h1FF, 9'h001, lat, d, c);
        total++;
        if ({lat == 4, c, d} !== {1'b1, 1'b1, 9'h000}) begin
            bad++;
            $display("FAIL wrap got lat=%0d c=%b d=%h exp lat=4 c=1 d=000", lat, c, d);
        end
        repeat (2) tick();
    endtask

    task automatic test_subtract();
        int lat;
        logic [W-1:0] d;
        logic c;
        do_op(9'h000, 9'h1FD, lat, d, c);
        total++;
        if ({lat == 4, c, d} !== {1'b1, 1'b0, 9'h1FD}) begin
            bad++;
            $display("FAIL sub_zero got lat=%0d c=%b d=%h exp lat=4 c=0 d=1fd", lat, c, d);
        end
        repeat (2) tick();
        do_op(9'h005, 9'h1FD, lat, d, c);
        total++;
        if ({lat == 4, c, d} !== {1'b1, 1'b1, 9'h002}) begin
            bad++;
            $display("FAIL sub_five got lat=%0d c=%b d=%h exp lat=4 c=1 d=002", lat, c, d);
        end
        repeat (2) tick();
    endtask

    task automatic test_handshake();
        int lat = -1;
        int acks = 0;
        bus.Adder_datain1 = 9'h0F0;
        bus.Adder_datain2 = 9'h00F;
        bus.Adder_valid = 1'b1;
        tick();
        bus.Adder_datain1 = 9'($urandom);
        bus.Adder_datain2 = 9'($urandom);
        for (int n = 2; n <= 12; n++) begin
            tick();
            if (bus.Adder_ack) begin lat = n; break; end
        end
        total++;
        if (lat !== 4) begin bad++; $display("FAIL hs_latency got=%0d exp=4", lat); end
        total++;
        if (bus.Adder_dataout !== 9'h0FF) begin bad++; $display("FAIL hs_operands_latched got=%h exp=0ff", bus.Adder_dataout); end
        tick();
        total++;
        if (bus.Adder_ack !== 1'b0 || bus.Adder_dataout !== 9'h0FF) begin
            bad++;
            $display("FAIL hs_gap got ack=%b d=%h exp ack=0 d=0ff", bus.Adder_ack, bus.Adder_dataout);
        end
        bus.Adder_valid = 1'b0;
        repeat (8) begin
            tick();
            if (bus.Adder_ack) acks++;
        end
        total++;
        if (acks !== 0 || bus.Adder_dataout !== 9'h0FF) begin
            bad++;
            $display("FAIL hs_no_second got acks=%0d d=%h exp acks=0 d=0ff", acks, bus.Adder_dataout);
        end
    endtask

    task automatic test_valid_drop();
        int lat = -1;
        bus.Adder_datain1 = 9'h0C3;
        bus.Adder_datain2 = 9'h12D;
        bus.Adder_valid = 1'b1;
        tick();
        bus.Adder_valid = 1'b0;
        for (int n = 2; n <= 12; n++) begin
            tick();
            if (bus.Adder_ack) begin lat = n; break; end
        end
        total++;
        if ({lat == 4, bus.Adder_carryout, bus.Adder_dataout} !== {1'b1, model(9'h0C3, 9'h12D)}) begin
            bad++;
            $display("FAIL valid_drop got lat=%0d c=%b d=%h exp lat=4 cd=%h", lat,
                     bus.Adder_carryout, bus.Adder_dataout, model(9'h0C3, 9'h12D));
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        int acks = 0;
        logic [W-1:0] d;
        logic c;
        bus.Adder_datain1 = 9'h123;
        bus.Adder_datain2 = 9'h045;
        bus.Adder_valid = 1'b1;
        tick();
        bus.Adder_valid = 1'b0;
        tick();
        RSTK = 1'b0;
        tick();
        RSTK = 1'b1;
        total++;
        if ({bus.Adder_ack, bus.Adder_carryout, bus.Adder_dataout} !== 11'h0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%h exp=0", {bus.Adder_ack, bus.Adder_carryout, bus.Adder_dataout});
        end
        repeat (8) begin
            tick();
            if (bus.Adder_ack) acks++;
        end
        total++;
        if (acks !== 0) begin bad++; $display("FAIL mid_reset_no_ack got=%0d exp=0", acks); end
        do_op(9'h00A, 9'h00B, lat, d, c);
        total++;
        if ({lat == 4, c, d} !== {1'b1, 1'b0, 9'h015}) begin
            bad++;
            $display("FAIL after_reset got lat=%0d c=%b d=%h exp lat=4 c=0 d=015", lat, c, d);
        end
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, t1;
        logic [W-1:0] d1, d2;
        logic c1, c2;
        do_op(9'h0AB, 9'h1CD, lat1, d1, c1);
        t1 = cyc;
        repeat (2) tick();
        do_op(9'h111, 9'h0EE, lat2, d2, c2);
        total++;
        if ({c1, d1} !== model(9'h0AB, 9'h1CD)) begin
            bad++;
            $display("FAIL b2b_first got=%h exp=%h", {c1, d1}, model(9'h0AB, 9'h1CD));
        end
        total++;
        if ({c2, d2} !== model(9'h111, 9'h0EE)) begin
            bad++;
            $display("FAIL b2b_second got=%h exp=%h", {c2, d2}, model(9'h111, 9'h0EE));
        end
        total++;
        if (lat1 !== 4 || lat2 !== 4 || cyc - t1 !== 6) begin
            bad++;
            $display("FAIL b2b_spacing got=%0d exp=6", cyc - t1);
        end
        repeat (2) tick();
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] a, b, d;
        logic c;
        for (int i = 0; i < 16; i++) begin
            a = 9'($urandom_range(0, 511));
            b = 9'($urandom_range(0, 511));
            repeat ($urandom_range(0, 3)) tick();
            do_op(a, b, lat, d, c);
            total++;
            if (lat !== 4 || {c, d} !== model(a, b)) begin
                bad++;
                $display("FAIL random a=%h b=%h got lat=%0d cd=%h exp lat=4 cd=%h", a, b, lat, {c, d}, model(a, b));
            end
            repeat (2) tick();
        end
    endtask

    initial begin
        bus.Adder_valid = 1'b0;
        bus.Adder_datain1 = '0;
        bus.Adder_datain2 = '0;
        test_reset();
        test_add();
        test_wrap();
        test_subtract();
        test_handshake();
        test_valid_drop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
